fp_result_queue: RTL and testbench
==================================

Name: fp_result_queue

Overview:
- Buffers packed, NaN-boxed FPU results and drives them into the FP register-file write port, one per granted cycle.
- Sits directly downstream of the FPU result packer and upstream of the FP register file.
- Also provides:
  - a pending-destination lookup for hazard detection
  - sticky accumulation of exception flags
  - a NaN-boxing integrity check on every push

Parameters:
- FLEN, 64, width of a packed FP result.
- DEPTH, 4, queue entries; must be a power of two, at least 2.
- RDW, 5, destination register index width.
- FMTBITS, 2, format field width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- InValid  in  1  a result is presented.
- InReady  out  1  queue can accept; InReady = ~Full.
- InResult  in  FLEN  packed result.
- InFmt  in  FMTBITS  result format: 0 single, 1 double, 2 half, 3 quad.
- InRd  in  RDW  destination register.
- InFlags  in  5  NV, DZ, OF, UF, NX for this result.
- Flush  in  1  discard all queued entries.
- RfGrant  in  1  register-file write port available this cycle.
- RfWe  out  1  write enable.
- RfWa  out  RDW  write address (head Rd).
- RfWd  out  FLEN  write data (head result).
- QueryRd  in  RDW  hazard lookup index.
- RdPending  out  1  QueryRd matches any valid entry.
- FlagsClr  in  1  clear accumulated flags.
- FlagsAcc  out  5  sticky OR of flags of retired entries.
- BoxErr  out  1  sticky: a pushed narrow result was not NaN-boxed.
- Count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (async assert, sync release): all valid bits 0, pointers 0, Count 0, FlagsAcc 0, BoxErr 0.
  - Outputs during reset: RfWe 0, InReady 1, RdPending 0.
  - Reset mid-operation drops all entries immediately.
- Storage: circular buffer with wr/rd pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; Count tracks occupancy. Full = (Count == DEPTH); Empty = (Count == 0).
- Push: InValid & InReady & ~Flush at the clock edge.
  - Writes {InResult, InRd, InFlags} at wr pointer and advances it.
  - No bypass: an entry pushed in cycle N is visible at the head no earlier than cycle N+1.
  - Minimum latency from push to RfWe is 1 cycle.
- Pop:
  - RfWe = ~Empty & RfGrant & ~Flush (combinational).
  - RfWa and RfWd always show the head entry; they are don't-care when Empty.
  - On RfWe the rd pointer advances and FlagsAcc is ORed with the head's flags at the edge.
- Simultaneous push and pop: Count unchanged.
  - When Full, the push is refused even if a pop occurs that cycle; InReady depends only on Count.
- Flush:
  - Next cycle: Count 0, pointers 0, all entries invalid.
  - Same-cycle push and pop are both suppressed; the suppressed pop's flags are not accumulated.
  - FlagsAcc and BoxErr are unaffected.
- FlagsClr:
  - Next-cycle FlagsAcc = the flags retired in that same cycle (clear-then-OR); 0 if nothing retired.
- RdPending (combinational): OR over valid entries of (entry Rd == QueryRd).
  - Entries being popped in the current cycle still count.
- Box check on each accepted push:
  - Boxed width per format (from the package): fmt 0 → 32, fmt 1 → 64, fmt 2 → 16, fmt 3 → 128.
  - If that width < FLEN and InResult[FLEN-1:width] is not all ones, BoxErr sets.
  - BoxErr clears only on reset.
  - Formats whose width ≥ FLEN are never checked.
- No state machine beyond the pointer/count logic. The next-state of every register is fully specified; there are no latches.

Decomposition:
- Package fp_queue_pkg holds:
  - format encodings FMT_S = 0, FMT_D = 1, FMT_H = 2, FMT_Q = 3
  - per-format boxed widths
  - the flags typedef (5-bit packed struct NV, DZ, OF, UF, NX)
  - the entry typedef {result, rd, flags}
- One sub-module, nanbox_check: combinational; inputs FLEN-wide result and fmt; output "bad box".
- The pointer/storage logic stays in the top module.

Test Plan:
- Fill and drain: push 4 results with Rd 1, 2, 3, 4 while RfGrant = 0.
  - Count = 4, InReady = 0; a 5th push is refused.
  - Then RfGrant = 1: RfWa is 1, 2, 3, 4 on consecutive cycles, data in order; Count returns to 0.
- Simultaneous push and pop at Count = 2 over 6 cycles: Count stays 2 and ordering is preserved.
  - At Count = 4 with pop asserted: the push is still refused and Count goes to 3.
- Flush:
  - With 3 entries and RfGrant = 1 in the same cycle: RfWe = 0 and the next-cycle Count = 0.
  - A FlagsAcc of 0 stays 0 despite head flags = 5'b10000.
- Flags: retire entries with flags 5'b00001 then 5'b01000 → FlagsAcc = 5'b01001.
  - FlagsClr in the same cycle as retiring 5'b00100 → FlagsAcc = 5'b00100.
- Hazard lookup: queue holds Rd 7 and Rd 12.
  - QueryRd = 12 → RdPending = 1; QueryRd = 3 → 0.
  - After Rd 12 retires, QueryRd = 12 → 0.
- Box check and reset, with FLEN = 64:
  - Push fmt 0 with upper 32 bits = 0xFFFFFFFF → BoxErr stays 0.
  - Push fmt 0 with upper bits = 0xFFFF0000 → BoxErr = 1.
  - Drop reset_n mid-drain: outputs return to reset values immediately, with no clock edge.

Source files
------------

// File: rtl/fp_queue_pkg.sv
// Shared types and constants for the FP result queue.
// Format codes, boxed widths, the flags struct and the entry layout.
package fp_queue_pkg;

   localparam logic [1:0] FMT_S = 2'd0;
   localparam logic [1:0] FMT_D = 2'd1;
   localparam logic [1:0] FMT_H = 2'd2;
   localparam logic [1:0] FMT_Q = 2'd3;

   localparam int WIDTH_S = 32;
   localparam int WIDTH_D = 64;
   localparam int WIDTH_H = 16;
   localparam int WIDTH_Q = 128;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } flags_t;

   localparam int ENT_FLEN = 64;
   localparam int ENT_RDW  = 5;

   typedef struct packed {
      logic [ENT_FLEN-1:0] result;
      logic [ENT_RDW-1:0]  rd;
      flags_t              flags;
   } entry_t;

   // Unknown codes map to the widest format so they are never checked.
   function automatic int box_width(input int fmt);
      int w;
      case (fmt)
         int'(FMT_S): w = WIDTH_S;
         int'(FMT_D): w = WIDTH_D;
         int'(FMT_H): w = WIDTH_H;
         default:     w = WIDTH_Q;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/nanbox_check.sv
// Flags a narrow FP result whose bits above its format width are not all ones.
// Ports: result/fmt in, bad out (combinational).
module nanbox_check
   import fp_queue_pkg::*;
#(
   parameter int FLEN    = 64,
   parameter int FMTBITS = 2
) (
   input  logic [FLEN-1:0]    result,
   input  logic [FMTBITS-1:0] fmt,
   output logic               bad
);

   int w;

   always_comb begin
      w   = box_width(int'(fmt));
      bad = 1'b0;
      // Formats as wide as the register never carry a box.
      if (w < FLEN) begin
         for (int i = 0; i < FLEN; i++) begin
            if (i >= w && !result[i]) bad = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_result_queue.sv
// Queue of NaN-boxed FPU results feeding the FP register-file write port.
// Ports: In* push side, Rf* write port, QueryRd/RdPending hazard, flags, BoxErr, Count.
module fp_result_queue
   import fp_queue_pkg::*;
#(
   parameter int FLEN    = 64,
   parameter int DEPTH   = 4,
   parameter int RDW     = 5,
   parameter int FMTBITS = 2
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   InValid,
   output logic                   InReady,
   input  logic [FLEN-1:0]        InResult,
   input  logic [FMTBITS-1:0]     InFmt,
   input  logic [RDW-1:0]         InRd,
   input  logic [4:0]             InFlags,
   input  logic                   Flush,
   input  logic                   RfGrant,
   output logic                   RfWe,
   output logic [RDW-1:0]         RfWa,
   output logic [FLEN-1:0]        RfWd,
   input  logic [RDW-1:0]         QueryRd,
   output logic                   RdPending,
   input  logic                   FlagsClr,
   output logic [4:0]             FlagsAcc,
   output logic                   BoxErr,
   output logic [$clog2(DEPTH):0] Count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [FLEN-1:0] result;
      logic [RDW-1:0]  rd;
      flags_t          flags;
   } slot_t;

   slot_t            mem [DEPTH];
   logic [DEPTH-1:0] valid;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   flags_t           acc;
   logic             box_err;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             bad_box;
   slot_t            head;

   nanbox_check #(
      .FLEN    (FLEN),
      .FMTBITS (FMTBITS)
   ) u_box (
      .result (InResult),
      .fmt    (InFmt),
      .bad    (bad_box)
   );

   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);
   assign push  = InValid & ~full & ~Flush;
   assign pop   = ~empty & RfGrant & ~Flush;
   assign head  = mem[rd_ptr];

   assign InReady  = ~full;
   assign RfWe     = pop;
   assign RfWa     = head.rd;
   assign RfWd     = head.result;
   assign FlagsAcc = acc;
   assign BoxErr   = box_err;
   assign Count    = cnt;

   // An entry being popped this cycle is still valid, so it still
   // blocks a reader until the write actually lands.
   always_comb begin
      RdPending = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i] && mem[i].rd == QueryRd) RdPending = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{
            result: InResult,
            rd:     InRd,
            flags:  flags_t'(InFlags)
         };
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (Flush) begin
         valid  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         // push and pop never hit the same slot: push needs
         // not-full, pop needs not-empty.
         if (push) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (pop) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
         end
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   // Clear-then-OR: a clear still keeps the flags retired alongside it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
      end else if (FlagsClr) begin
         acc <= pop ? head.flags : '0;
      end else if (pop) begin
         acc <= acc | head.flags;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         box_err <= 1'b0;
      end else if (push && bad_box) begin
         box_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fp_result_queue.sv
// Scoreboard bench for fp_result_queue.
// Stimulus pushes expected writes; a negedge monitor checks each RfWe.
module tb_fp_result_queue;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        InValid;
   logic        InReady;
   logic [63:0] InResult;
   logic [1:0]  InFmt;
   logic [4:0]  InRd;
   logic [4:0]  InFlags;
   logic        Flush;
   logic        RfGrant;
   logic        RfWe;
   logic [4:0]  RfWa;
   logic [63:0] RfWd;
   logic [4:0]  QueryRd;
   logic        RdPending;
   logic        FlagsClr;
   logic [4:0]  FlagsAcc;
   logic        BoxErr;
   logic [2:0]  Count;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fp_result_queue dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .InValid   (InValid),
      .InReady   (InReady),
      .InResult  (InResult),
      .InFmt     (InFmt),
      .InRd      (InRd),
      .InFlags   (InFlags),
      .Flush     (Flush),
      .RfGrant   (RfGrant),
      .RfWe      (RfWe),
      .RfWa      (RfWa),
      .RfWd      (RfWd),
      .QueryRd   (QueryRd),
      .RdPending (RdPending),
      .FlagsClr  (FlagsClr),
      .FlagsAcc  (FlagsAcc),
      .BoxErr    (BoxErr),
      .Count     (Count)
   );

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] dat(input logic [4:0] rd);
      return 64'hD00D_0000_0000_0000 | 64'(rd);
   endfunction

   // Drive one push for the next edge; exp_ok says it should be accepted.
   task automatic drive(input logic [4:0] rd, input logic [63:0] d,
                        input logic [1:0] fmt, input logic [4:0] fl,
                        input bit exp_ok);
      InValid  = 1'b1;
      InRd     = rd;
      InResult = d;
      InFmt    = fmt;
      InFlags  = fl;
      if (exp_ok) exp_q.push_back('{rd: rd, data: d});
   endtask

   always @(negedge clk) begin
      if (reset_n && RfWe) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: got rd %0d want none", RfWa);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rf_wa", 128'(RfWa), 128'(e.rd));
            chk("rf_wd", 128'(RfWd), 128'(e.data));
         end
      end
   end

   initial begin
      reset_n  = 1'b0;
      InValid  = 1'b0;
      InResult = '0;
      InFmt    = 2'd1;
      InRd     = '0;
      InFlags  = '0;
      Flush    = 1'b0;
      RfGrant  = 1'b0;
      QueryRd  = '0;
      FlagsClr = 1'b0;
      #2;
      chk("rst_we", 128'(RfWe), 128'(0));
      chk("rst_ready", 128'(InReady), 128'(1));
      chk("rst_pend", 128'(RdPending), 128'(0));
      chk("rst_count", 128'(Count), 128'(0));
      chk("rst_flags", 128'(FlagsAcc), 128'(0));
      chk("rst_boxerr", 128'(BoxErr), 128'(0));
      #20;
      reset_n = 1'b1;
      cyc();

      // Fill with grant low, then refuse a fifth push.
      for (int i = 1; i <= 4; i++) begin
         drive(5'(i), dat(5'(i)), 2'd1, 5'd0, 1'b1);
         cyc();
      end
      chk("fill_count", 128'(Count), 128'(4));
      chk("fill_ready", 128'(InReady), 128'(0));
      drive(5'd9, dat(5'd9), 2'd1, 5'd0, 1'b0);
      cyc();
      chk("refuse_count", 128'(Count), 128'(4));
      InValid = 1'b0;
      RfGrant = 1'b1;
      repeat (4) cyc();
      RfGrant = 1'b0;
      chk("drain_count", 128'(Count), 128'(0));
      chk("drain_sb", 128'(exp_q.size()), 128'(0));

      // Concurrent push/pop at occupancy 2.
      drive(5'd10, dat(5'd10), 2'd1, 5'd0, 1'b1);
      cyc();
      drive(5'd11, dat(5'd11), 2'd1, 5'd0, 1'b1);
      cyc();
      RfGrant = 1'b1;
      for (int k = 0; k < 6; k++) begin
         drive(5'(20 + k), dat(5'(20 + k)), 2'd1, 5'd0, 1'b1);
         cyc();
         chk("pp_count", 128'(Count), 128'(2));
      end
      RfGrant = 1'b0;
      drive(5'd26, dat(5'd26), 2'd1, 5'd0, 1'b1);
      cyc();
      drive(5'd27, dat(5'd27), 2'd1, 5'd0, 1'b1);
      cyc();
      chk("pp_full", 128'(Count), 128'(4));
      drive(5'd28, dat(5'd28), 2'd1, 5'd0, 1'b0);
      RfGrant = 1'b1;
      cyc();
      chk("full_pop_count", 128'(Count), 128'(3));
      InValid = 1'b0;
      repeat (3) cyc();
      RfGrant = 1'b0;
      chk("pp_drain", 128'(Count), 128'(0));

      // Flush with three entries, grant and a push in the same cycle.
      for (int i = 0; i < 3; i++) begin
         drive(5'(13 + i), dat(5'(13 + i)), 2'd1, 5'b10000, 1'b1);
         cyc();
      end
      Flush   = 1'b1;
      RfGrant = 1'b1;
      drive(5'd30, dat(5'd30), 2'd1, 5'd0, 1'b0);
      #1;
      chk("flush_we", 128'(RfWe), 128'(0));
      cyc();
      exp_q.delete();
      Flush   = 1'b0;
      RfGrant = 1'b0;
      InValid = 1'b0;
      chk("flush_count", 128'(Count), 128'(0));
      chk("flush_flags", 128'(FlagsAcc), 128'(0));
      chk("flush_ready", 128'(InReady), 128'(1));

      // Flag accumulation and clear-then-OR.
      drive(5'd1, dat(5'd1), 2'd1, 5'b00001, 1'b1);
      cyc();
      drive(5'd2, dat(5'd2), 2'd1, 5'b01000, 1'b1);
      cyc();
      drive(5'd3, dat(5'd3), 2'd1, 5'b00100, 1'b1);
      cyc();
      InValid = 1'b0;
      RfGrant = 1'b1;
      repeat (2) cyc();
      chk("flags_or", 128'(FlagsAcc), 128'(5'b01001));
      FlagsClr = 1'b1;
      cyc();
      FlagsClr = 1'b0;
      RfGrant  = 1'b0;
      chk("flags_clr", 128'(FlagsAcc), 128'(5'b00100));

      // Hazard lookup.
      drive(5'd7, dat(5'd7), 2'd1, 5'd0, 1'b1);
      cyc();
      drive(5'd12, dat(5'd12), 2'd1, 5'd0, 1'b1);
      cyc();
      InValid = 1'b0;
      QueryRd = 5'd12;
      #1;
      chk("pend_12", 128'(RdPending), 128'(1));
      QueryRd = 5'd3;
      #1;
      chk("pend_3", 128'(RdPending), 128'(0));
      QueryRd = 5'd7;
      RfGrant = 1'b1;
      #1;
      chk("pend_popping", 128'(RdPending), 128'(1));
      cyc();
      chk("pend_7_gone", 128'(RdPending), 128'(0));
      QueryRd = 5'd12;
      #1;
      chk("pend_12_still", 128'(RdPending), 128'(1));
      cyc();
      RfGrant = 1'b0;
      chk("pend_12_gone", 128'(RdPending), 128'(0));

      // Box check; all entries carry NX so a reset clear is visible.
      FlagsClr = 1'b1;
      cyc();
      FlagsClr = 1'b0;
      drive(5'd4, 64'h0000_0000_1234_5678, 2'd1, 5'b00001, 1'b1);
      cyc();
      chk("box_d", 128'(BoxErr), 128'(0));
      drive(5'd5, 64'hFFFF_FFFF_FFFF_3C00, 2'd2, 5'b00001, 1'b1);
      cyc();
      chk("box_h", 128'(BoxErr), 128'(0));
      drive(5'd6, 64'hFFFF_FFFF_3F80_0000, 2'd0, 5'b00001, 1'b1);
      cyc();
      chk("box_s_ok", 128'(BoxErr), 128'(0));
      drive(5'd8, 64'hFFFF_0000_3F80_0000, 2'd0, 5'b00001, 1'b1);
      cyc();
      InValid = 1'b0;
      chk("box_s_bad", 128'(BoxErr), 128'(1));

      // Reset in the middle of draining.
      RfGrant = 1'b1;
      repeat (2) cyc();
      chk("mid_flags", 128'(FlagsAcc), 128'(5'b00001));
      QueryRd = 5'd8;
      #1;
      chk("mid_pend", 128'(RdPending), 128'(1));
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      chk("ar_we", 128'(RfWe), 128'(0));
      chk("ar_ready", 128'(InReady), 128'(1));
      chk("ar_count", 128'(Count), 128'(0));
      chk("ar_pend", 128'(RdPending), 128'(0));
      chk("ar_flags", 128'(FlagsAcc), 128'(0));
      chk("ar_boxerr", 128'(BoxErr), 128'(0));
      RfGrant = 1'b0;
      #12;
      reset_n = 1'b1;
      repeat (2) cyc();
      chk("end_sb", 128'(exp_q.size()), 128'(0));
      chk("end_count", 128'(Count), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
